axi_read_responder: RTL
=======================

// Module: axi_read_responder
// PURPOSE
//  Slave-side AXI read responder: accepts AR requests (ID already widened with master tag) and
//  returns R beats on the slave port of the read-data interconnect. Reads a 1-cycle sync SRAM
//  (CS/OE/A/DO) and honours RREADY backpressure. Sits between interconnect S-port and memory.
// PARAMETERS
//  ADDR_WIDTH  14   SRAM word-address width; A = addr_q[ADDR_WIDTH+1:2]
// PORTS
//  clk        in   1                 clock, all state on posedge
//  rst        in   1                 async active-low reset
//  ARID_S     in   `AXI_IDS_BITS     {master tag, ID}; returned verbatim on RID_S
//  ARADDR_S   in   `AXI_ADDR_BITS    byte start address
//  ARLEN_S    in   `AXI_LEN_BITS     beats-1
//  ARSIZE_S   in   `AXI_SIZE_BITS    must be 3'b010 (4 B)
//  ARBURST_S  in   2                 00 FIXED, 01 INCR, 10 WRAP
//  ARVALID_S  in   1                 request valid
//  ARREADY_S  out  1                 request accept
//  RID_S      out  `AXI_IDS_BITS     response ID
//  RDATA_S    out  `AXI_DATA_BITS    read data (registered)
//  RRESP_S    out  2                 00 OKAY, 10 SLVERR
//  RLAST_S    out  1                 final beat
//  RVALID_S   out  1                 beat valid
//  RREADY_S   in   1                 beat accept
//  CS, OE     out  1 each            SRAM chip select / output enable, asserted only in FETCH
//  A          out  ADDR_WIDTH        SRAM word address
//  DO         in   `AXI_DATA_BITS    SRAM read data, valid cycle after FETCH
// BEHAVIOUR
//  Reset: state IDLE; ARREADY_S=1; RVALID_S=RLAST_S=0; RID_S, RDATA_S, RRESP_S, CS, OE, A = 0.
//  FSM IDLE->FETCH->WAIT->RESP. IDLE: ARREADY_S=1; on ARVALID_S&ARREADY_S latch id/addr/len/
//   burst, cnt=0, err=(ARSIZE_S!=3'b010)|(unsupported burst); -> FETCH. ARREADY_S=0 outside IDLE.
//  FETCH: CS=OE=(~err), A=addr_q word index; -> WAIT. WAIT: rdata_q<=err?0:DO; -> RESP.
//  RESP: RVALID_S=1, RDATA_S=rdata_q, RRESP_S=err?2'b10:2'b00, RLAST_S=(cnt==len_q).
//   All R outputs stable while RVALID_S&~RREADY_S (no change, no new fetch).
//   On RVALID_S&RREADY_S: if RLAST_S -> IDLE; else cnt++, addr_q<=next addr, -> FETCH.
//  Latency: AR handshake cycle N -> first RVALID_S cycle N+3; 3 cycles/beat with RREADY_S=1.
//  Next addr: FIXED unchanged; INCR addr+4 (32-bit wrap-around, no 4KB check);
//   WRAP see CONFIGURATION. Beat count = ARLEN_S+1 always, including error bursts.
//  Error bursts: no SRAM access (CS=0), data 0, SLVERR on every beat, RLAST on last.
//  Back-to-back: next AR accepted earliest the cycle after final R handshake (IDLE).
//  Reset mid-burst: immediate return to reset values; in-flight burst discarded.
// CONFIGURATION
//  AXI_RD_WRAP_EN defined: ARBURST 2'b10 legal when ARLEN_S in {1,3,7,15}; next addr =
//   (addr & ~mask) | ((addr+4) & mask), mask=((len+1)*4)-1; other lengths -> SLVERR.
//  Undefined: ARBURST 2'b10 and 2'b11 -> SLVERR burst. 2'b11 always SLVERR.
// STRUCTURE
//  axi_rd_pkg: state enum {IDLE,FETCH,WAIT,RESP}, BURST_FIXED/INCR/WRAP, RESP_OKAY/SLVERR.
//  Widths from AXI_define.svh. Sub-module axi_rd_addr_gen: combinational next-address
//   (addr, len, burst -> next_addr), holds the AXI_RD_WRAP_EN logic.
// TESTING
//  1 INCR ARADDR=0x100, LEN=3, RREADY=1 -> A=0x40..0x43, 4 beats OKAY, RLAST on 4th, first RVALID N+3.
//  2 Same, RREADY low 5 cycles on beat 2 -> RDATA/RID/RLAST held stable, CS=0, no extra beat.
//  3 ARSIZE=3'b001, LEN=1 -> 2 beats RRESP=10, RDATA=0, CS never asserted.
//  4 FIXED ARADDR=0x20, LEN=2 -> A=0x08 three times; RID_S = ARID_S (e.g. 8'h13).
//  5 WRAP ARADDR=0x0C, LEN=3: with AXI_RD_WRAP_EN A=3,0,1,2 OKAY; without -> 4 SLVERR beats.
//  6 rst low during beat 2 -> next cycle RVALID=0, ARREADY=1; new AR after reset served normally.

Source files
------------

// File: rtl/axi_rd_pkg.sv
// Shared types and constants for the AXI read responder.
//   rd_state_e    : responder FSM states
//   BURST_*       : ARBURST encodings
//   RESP_*        : RRESP encodings
//   AXI_*_BITS    : AXI channel field widths
package axi_rd_pkg;

    localparam int AXI_IDS_BITS  = 8;
    localparam int AXI_ADDR_BITS = 32;
    localparam int AXI_LEN_BITS  = 4;
    localparam int AXI_SIZE_BITS = 3;
    localparam int AXI_DATA_BITS = 32;

    typedef enum logic [1:0] {
        IDLE,
        FETCH,
        WAIT,
        RESP
    } rd_state_e;

    localparam logic [1:0] BURST_FIXED = 2'b00;
    localparam logic [1:0] BURST_INCR  = 2'b01;
    localparam logic [1:0] BURST_WRAP  = 2'b10;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    localparam logic [AXI_SIZE_BITS-1:0] SIZE_4B = 3'b010;

endpackage

// File: rtl/axi_rd_addr_gen.sv
// Combinational next-beat address generator and burst-type legality check.
// Optional feature macro: AXI_RD_WRAP_EN enables WRAP bursts of 2/4/8/16 beats;
// without it every WRAP burst is reported illegal.
//   addr      in  current beat byte address
//   len       in  burst length (beats-1)
//   burst     in  burst type
//   next_addr out byte address of the following beat
//   burst_ok  out burst type/length combination is supported
module axi_rd_addr_gen
    import axi_rd_pkg::*;
(
    input  logic [AXI_ADDR_BITS-1:0] addr,
    input  logic [AXI_LEN_BITS-1:0]  len,
    input  logic [1:0]               burst,
    output logic [AXI_ADDR_BITS-1:0] next_addr,
    output logic                     burst_ok
);

    logic [AXI_ADDR_BITS-1:0] incr_addr;
    logic [AXI_ADDR_BITS-1:0] wrap_mask;
    logic [AXI_ADDR_BITS-1:0] wrap_addr;
    logic                     wrap_ok;

    always_comb begin
        incr_addr = addr + 32'd4;
        // Mask covers the byte span of the whole burst, so only the low bits advance.
        wrap_mask = ((AXI_ADDR_BITS'(len) + 32'd1) << 2) - 32'd1;
        wrap_addr = (addr & ~wrap_mask) | (incr_addr & wrap_mask);
`ifdef AXI_RD_WRAP_EN
        wrap_ok   = (len == 4'd1) || (len == 4'd3) || (len == 4'd7) || (len == 4'd15);
`else
        wrap_ok   = 1'b0;
`endif
    end

    always_comb begin
        next_addr = addr;
        burst_ok  = 1'b0;
        unique case (burst)
            BURST_FIXED: begin
                next_addr = addr;
                burst_ok  = 1'b1;
            end
            BURST_INCR: begin
                next_addr = incr_addr;
                burst_ok  = 1'b1;
            end
            BURST_WRAP: begin
                next_addr = wrap_addr;
                burst_ok  = wrap_ok;
            end
            default: begin
                next_addr = addr;
                burst_ok  = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/axi_read_responder.sv
// AXI slave-side read responder in front of a 1-cycle synchronous SRAM.
// Accepts one AR request at a time and returns ARLEN+1 R beats, one SRAM fetch
// per beat (IDLE -> FETCH -> WAIT -> RESP), honouring RREADY backpressure.
// Optional feature macro: AXI_RD_WRAP_EN (WRAP burst support, see axi_rd_addr_gen).
//   clk, rst        clock / asynchronous active-low reset
//   AR*_S           read address channel (ARID carries the master tag)
//   R*_S            read data channel
//   CS, OE, A, DO   SRAM chip select, output enable, word address, read data
module axi_read_responder
    import axi_rd_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH = 14
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [AXI_IDS_BITS-1:0]  ARID_S,
    input  logic [AXI_ADDR_BITS-1:0] ARADDR_S,
    input  logic [AXI_LEN_BITS-1:0]  ARLEN_S,
    input  logic [AXI_SIZE_BITS-1:0] ARSIZE_S,
    input  logic [1:0]               ARBURST_S,
    input  logic                     ARVALID_S,
    output logic                     ARREADY_S,
    output logic [AXI_IDS_BITS-1:0]  RID_S,
    output logic [AXI_DATA_BITS-1:0] RDATA_S,
    output logic [1:0]               RRESP_S,
    output logic                     RLAST_S,
    output logic                     RVALID_S,
    input  logic                     RREADY_S,
    output logic                     CS,
    output logic                     OE,
    output logic [ADDR_WIDTH-1:0]    A,
    input  logic [AXI_DATA_BITS-1:0] DO
);

    rd_state_e                state_q, state_d;
    logic [AXI_IDS_BITS-1:0]  id_q;
    logic [AXI_ADDR_BITS-1:0] addr_q;
    logic [AXI_LEN_BITS-1:0]  len_q;
    logic [1:0]               burst_q;
    logic [AXI_LEN_BITS-1:0]  cnt_q;
    logic                     size_err_q;
    logic [AXI_DATA_BITS-1:0] rdata_q;

    logic [AXI_ADDR_BITS-1:0] next_addr;
    logic                     burst_ok;
    logic                     err;
    logic                     last_beat;
    logic                     ar_fire;
    logic                     r_fire;

    // Legality is judged on the latched request; it is ready by the first FETCH.
    axi_rd_addr_gen u_addr_gen (
        .addr      (addr_q),
        .len       (len_q),
        .burst     (burst_q),
        .next_addr (next_addr),
        .burst_ok  (burst_ok)
    );

    assign err       = size_err_q | ~burst_ok;
    assign last_beat = (cnt_q == len_q);
    assign ar_fire   = ARVALID_S & ARREADY_S;
    assign r_fire    = RVALID_S & RREADY_S;

    always_comb begin
        state_d   = state_q;
        ARREADY_S = 1'b0;
        RVALID_S  = 1'b0;
        CS        = 1'b0;
        unique case (state_q)
            IDLE: begin
                ARREADY_S = 1'b1;
                if (ARVALID_S) state_d = FETCH;
            end
            FETCH: begin
                CS      = ~err;
                state_d = WAIT;
            end
            WAIT: begin
                state_d = RESP;
            end
            RESP: begin
                RVALID_S = 1'b1;
                if (RREADY_S) state_d = last_beat ? IDLE : FETCH;
            end
        endcase
    end

    assign OE      = CS;
    assign A       = addr_q[ADDR_WIDTH+1:2];
    assign RID_S   = id_q;
    assign RDATA_S = rdata_q;
    assign RRESP_S = (RVALID_S && err) ? RESP_SLVERR : RESP_OKAY;
    assign RLAST_S = RVALID_S & last_beat;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= IDLE;
            id_q       <= '0;
            addr_q     <= '0;
            len_q      <= '0;
            burst_q    <= BURST_FIXED;
            cnt_q      <= '0;
            size_err_q <= 1'b0;
            rdata_q    <= '0;
        end else begin
            state_q <= state_d;
            if (ar_fire) begin
                id_q       <= ARID_S;
                addr_q     <= ARADDR_S;
                len_q      <= ARLEN_S;
                burst_q    <= ARBURST_S;
                cnt_q      <= '0;
                size_err_q <= (ARSIZE_S != SIZE_4B);
            end
            // SRAM data is valid in the cycle after FETCH.
            if (state_q == WAIT) begin
                rdata_q <= err ? '0 : DO;
            end
            if (r_fire && !last_beat) begin
                cnt_q  <= cnt_q + 4'd1;
                addr_q <= next_addr;
            end
        end
    end

endmodule
